// File: rtl/key_pkg.sv
// Shared key-matrix types: key count, event index width and the {index, level} event record.
// Used by the event queue and by the downstream report builder.
package key_pkg;
  localparam int KEYS       = 89;
  localparam int IDX_W      = 7;
  localparam int EVT_W      = IDX_W + 1;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 4;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             level;
  } key_evt_t;

  // Round-robin successor; the scanner never holds an index >= KEYS.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(KEYS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event stream from the key event queue to the host-link stage.
// Payload is the head event {index, level}, stable while valid is high and ready is low.
interface key_event_queue_if;
  import key_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_index;
  logic             evt_level;

  modport master (output evt_valid, output evt_index, output evt_level, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_index, input  evt_level, output evt_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Show-ahead FIFO: head visible the cycle after the write edge; pop advances the head.
// Writes while full and pops while empty are dropped; an empty FIFO presents the last popped head.
module key_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign count   = cnt;
  assign rd_dat  = (cnt != '0) ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/key_event_queue.sv
// Scans one key per cycle against a last-reported snapshot and queues each level change as an event.
// Full FIFO stalls the scanner on the changed key; changes are never lost, toggles coalesce.
module key_event_queue
  import key_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [KEYS-1:0]   keys_i,
  key_event_queue_if.master evt,
  output logic [PTR_W:0]    evt_count_o,
  output logic              stall_o
);
  logic [IDX_W-1:0] scan_idx;
  logic [KEYS-1:0]  snapshot;
  logic             cur_lvl;
  logic             change;
  logic             full;
  logic             push;
  logic [PTR_W:0]   count;
  key_evt_t         wr_evt;
  key_evt_t         rd_evt;

  assign cur_lvl = keys_i[scan_idx];
  assign change  = cur_lvl != snapshot[scan_idx];
  // Registered count only: a same-cycle pop does not make room for this push.
  assign full    = count == (PTR_W+1)'(FIFO_DEPTH);
  assign push    = change && !full;
  assign stall_o = change && full;

  assign wr_evt.index = scan_idx;
  assign wr_evt.level = cur_lvl;

  // Snapshot resets to all ones to match the debouncer's reset level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scan_idx <= '0;
      snapshot <= '1;
    end else begin
      if (push) begin
        snapshot[scan_idx] <= cur_lvl;
      end
      if (!stall_o) begin
        scan_idx <= next_idx(scan_idx);
      end
    end
  end

  key_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .wr_dat  (wr_evt),
    .pop     (evt.evt_valid && evt.evt_ready),
    .rd_dat  (rd_evt),
    .count   (count)
  );

  assign evt.evt_valid = count != '0;
  assign evt.evt_index = rd_evt.index;
  assign evt.evt_level = rd_evt.level;
  assign evt_count_o   = count;
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: reference scan/FIFO model with event scoreboard, table vectors and corner sequences.
module tb_key_event_queue;
  import key_pkg::*;

  typedef struct {
    int key;
    bit lvl;
    int exp_idx;
    bit exp_lvl;
  } vec_t;

  typedef struct {
    int idx;
    bit lvl;
  } ev_t;

  logic            clk_i   = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [KEYS-1:0] keys    = '1;
  logic [PTR_W:0]  evt_count;
  logic            stall;

  key_event_queue_if evt_if ();

  key_event_queue dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .keys_i      (keys),
    .evt         (evt_if),
    .evt_count_o (evt_count),
    .stall_o     (stall)
  );

  always #5 clk_i = ~clk_i;

  int   checks   = 0;
  int   failures = 0;
  ev_t  m_q[$];
  ev_t  log_q[$];
  int   m_scan = 0;
  bit   m_snap [KEYS];
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model runs on the falling edge: compare current outputs, then advance to the next rising edge.
  always @(negedge clk_i) begin : mon
    bit  ch;
    bit  full;
    int  sz;
    ev_t e;
    if (!rst_n_i) begin
      m_q.delete();
      m_scan = 0;
      foreach (m_snap[i]) m_snap[i] = 1'b1;
    end
    ch   = keys[m_scan] != m_snap[m_scan];
    full = m_q.size() == FIFO_DEPTH;
    check("valid", int'(evt_if.evt_valid), int'(m_q.size() != 0));
    check("count", int'(evt_count), m_q.size());
    check("stall", int'(stall), int'(ch && full));
    if (m_q.size() != 0) begin
      check("head_idx", int'(evt_if.evt_index), m_q[0].idx);
      check("head_lvl", int'(evt_if.evt_level), int'(m_q[0].lvl));
    end
    if (rst_n_i) begin
      sz = m_q.size();
      if (sz != 0 && evt_if.evt_ready) begin
        e.idx = int'(evt_if.evt_index);
        e.lvl = evt_if.evt_level;
        log_q.push_back(e);
        void'(m_q.pop_front());
      end
      if (ch && sz < FIFO_DEPTH) begin
        e.idx = m_scan;
        e.lvl = keys[m_scan];
        m_q.push_back(e);
        m_snap[m_scan] = keys[m_scan];
      end
      if (!(ch && full)) m_scan = (m_scan == KEYS - 1) ? 0 : m_scan + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic wait_scan(input int idx);
    int c = 0;
    while (m_scan != idx && c < 200) begin
      tick(1);
      c++;
    end
    check("wait_scan", m_scan, idx);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check("wait_events", int'(log_q.size() >= n), 1);
  endtask

  initial begin : stim
    int c;
    int n30;
    vecs[0] = '{5,  1'b0, 5,  1'b0};
    vecs[1] = '{5,  1'b1, 5,  1'b1};
    vecs[2] = '{88, 1'b0, 88, 1'b0};
    vecs[3] = '{0,  1'b0, 0,  1'b0};
    vecs[4] = '{88, 1'b1, 88, 1'b1};
    vecs[5] = '{0,  1'b1, 0,  1'b1};
    vecs[6] = '{44, 1'b0, 44, 1'b0};
    vecs[7] = '{44, 1'b1, 44, 1'b1};
    evt_if.evt_ready = 1'b0;

    // Reset idle
    tick(5);
    check("rst_valid", int'(evt_if.evt_valid), 0);
    check("rst_count", int'(evt_count), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_index", int'(evt_if.evt_index), 0);
    check("rst_level", int'(evt_if.evt_level), 0);
    rst_n_i = 1'b1;
    evt_if.evt_ready = 1'b1;
    tick(300);
    check("idle_events", log_q.size(), 0);

    // Single-key vectors: exactly one event per level change
    for (int i = 0; i < 8; i++) begin
      log_q.delete();
      keys[vecs[i].key] = vecs[i].lvl;
      wait_log(1, 95);
      tick(100);
      check("vec_events", log_q.size(), 1);
      if (log_q.size() >= 1) begin
        check("vec_idx", log_q[0].idx, vecs[i].exp_idx);
        check("vec_lvl", int'(log_q[0].lvl), int'(vecs[i].exp_lvl));
      end
    end

    // Scan order across the wrap: scanner at 10, keys 88 and 3 change together
    log_q.delete();
    wait_scan(10);
    keys[88] = 1'b0;
    keys[3]  = 1'b0;
    wait_log(2, 120);
    check("wrap_events", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("wrap_first", log_q[0].idx, 88);
      check("wrap_second", log_q[1].idx, 3);
    end
    keys[88] = 1'b1;
    keys[3]  = 1'b1;
    tick(120);

    // Backpressure: fill to 16 and stall on key 16
    log_q.delete();
    wait_scan(0);
    evt_if.evt_ready = 1'b0;
    keys[19:0] = '0;
    tick(40);
    check("bp_count", int'(evt_count), 16);
    check("bp_stall", int'(stall), 1);
    check("bp_valid", int'(evt_if.evt_valid), 1);
    check("bp_head_idx", int'(evt_if.evt_index), 0);
    check("bp_head_lvl", int'(evt_if.evt_level), 0);
    // Coalescing: key 30 toggles and returns while the scanner is held
    keys[30] = 1'b0;
    tick(3);
    keys[30] = 1'b1;
    tick(3);
    check("bp_head_stable", int'(evt_if.evt_index), 0);
    check("bp_stall_held", int'(stall), 1);
    evt_if.evt_ready = 1'b1;
    wait_log(20, 200);
    tick(120);
    check("bp_events", log_q.size(), 20);
    n30 = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (i < 20) check("bp_order", log_q[i].idx, i);
      if (log_q[i].idx == 30) n30++;
    end
    check("coalesce_30", n30, 0);
    keys[19:0] = '1;
    tick(150);

    // Async reset with 7 queued events
    log_q.delete();
    wait_scan(0);
    evt_if.evt_ready = 1'b0;
    keys[6:0] = '0;
    c = 0;
    while (evt_count != 7 && c < 100) begin
      tick(1);
      c++;
    end
    check("pre_rst_count", int'(evt_count), 7);
    tick(3);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("arst_valid", int'(evt_if.evt_valid), 0);
    check("arst_count", int'(evt_count), 0);
    check("arst_stall", int'(stall), 0);
    check("arst_index", int'(evt_if.evt_index), 0);
    tick(2);
    log_q.delete();
    rst_n_i = 1'b1;
    evt_if.evt_ready = 1'b1;
    wait_log(7, 120);
    tick(20);
    check("rerep_events", log_q.size(), 7);
    for (int i = 0; i < log_q.size(); i++) begin
      if (i < 7) begin
        check("rerep_idx", log_q[i].idx, i);
        check("rerep_lvl", int'(log_q[i].lvl), 0);
      end
    end
    keys = '1;
    tick(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
